// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// clear-sequencer state encoding and a depth helper.
package reg_file_mp_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: two read ports, one write port, bulk-clear
// request and busy status. The master drives addresses/data/strobes, the
// slave (register file) returns read data and busy.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr_req;
  logic              busy;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data1, rd_data2, busy
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
    output rd_data1, rd_data2, busy
  );
endinterface

// File: rtl/reg_file_clr_seq.sv
// Bulk-clear sequencer: on clr_req in IDLE it walks a counter over every
// address (ascending), one per cycle, then returns to IDLE with the counter
// wrapped back to 0. Requests while clearing are ignored.
module reg_file_clr_seq
  import reg_file_mp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic              clr_en_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Next-state: start on request, advance one address per cycle, exit after the last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_en_o   = (state_q == CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Two-read / one-write register file with combinational reads, optional
// hardwired-zero register 0 and a bulk clear that zeroes one entry per cycle.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_mp_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              busy;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;
  logic [DATA_W-1:0] rd1, rd2;

  reg_file_clr_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_req_i (bus.clr_req),
    .busy_o    (busy),
    .clr_en_o  (clr_en),
    .clr_addr_o(clr_addr)
  );

  // A write commits only in IDLE without a competing clear, and never to a hardwired r0.
  assign wr_ok = bus.wr_en && !busy && !bus.clr_req &&
                 !((ZERO_REG != 0) && (bus.wr_addr == '0));

  // Storage: reset zeroes everything; clear and write are exclusive since wr_ok needs !busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_en) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read muxes: stored value, optional forwarding, then forced-zero cases take priority.
  always_comb begin
    rd1 = mem_q[bus.rd_addr1];
    rd2 = mem_q[bus.rd_addr2];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (bus.wr_addr == bus.rd_addr1)) rd1 = bus.wr_data;
    if (wr_ok && (bus.wr_addr == bus.rd_addr2)) rd2 = bus.wr_data;
`endif
    if (busy || ((ZERO_REG != 0) && (bus.rd_addr1 == '0))) rd1 = '0;
    if (busy || ((ZERO_REG != 0) && (bus.rd_addr2 == '0))) rd2 = '0;
  end

  assign bus.rd_data1 = rd1;
  assign bus.rd_data2 = rd2;
  assign bus.busy     = busy;

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, is the register width in bits.
REQ-002 Parameter ADDR_W, default 5, is the address width; depth DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-004 Port clk, input, 1, is the single clock; all state updates on posedge clk.
REQ-005 Port rst, input, 1, is the asynchronous, active-high reset.
REQ-006 Port rd_addr1 / rd_addr2, input, ADDR_W each, are the read port 1 and read port 2 addresses.
REQ-007 Port rd_data1 / rd_data2, output, DATA_W each, are the combinational read data.
REQ-008 Port wr_en, input, 1, is the write strobe.
REQ-009 Port wr_addr, input, ADDR_W, is the write address.
REQ-010 Port wr_data, input, DATA_W, is the write data.
REQ-011 Port clr_req, input, 1, is a single-cycle pulse requesting a bulk clear.
REQ-012 Port busy, output, 1, is high while a bulk clear is in progress.

Function
REQ-013 Reads shall be combinational: rd_dataN = reg[rd_addrN], with zero latency.
REQ-014 Writes shall update reg[wr_addr] at the posedge where wr_en=1, state=IDLE and clr_req=0.
- The write must be indexed by wr_addr, never by wr_en.
REQ-015 With ZERO_REG=1:
- Writes to address 0 are discarded.
- rd_dataN = 0 whenever rd_addrN = 0.
REQ-016 The FSM has two states, IDLE and CLEAR.
- IDLE -> CLEAR on clr_req=1; clear counter loads 0.
- CLEAR -> IDLE after the cycle that clears address DEPTH-1.
REQ-017 In CLEAR, one register is zeroed per cycle, in ascending address order (counter 0..DEPTH-1).
- A clear takes exactly DEPTH cycles.
- The counter wraps to 0 on exit.
REQ-018 busy = 1 exactly when state = CLEAR; busy is registered, so it rises the cycle after clr_req.
REQ-019 While busy = 1, wr_en is ignored and the write is dropped, not queued.
REQ-020 While busy = 1, clr_req is ignored; a clear does not restart.
REQ-021 While busy = 1, rd_data1 and rd_data2 are forced to 0.
REQ-022 If clr_req and wr_en are high together in IDLE, the clear wins and the write is dropped.
REQ-023 Reads from and writes to the same address in one cycle return the old value, unless REGFILE_BYPASS_EN is defined (see REQ-026).

Reset
REQ-024 When rst is asserted:
- All DEPTH registers are 0.
- state = IDLE, counter = 0, busy = 0.
- This takes effect immediately, independent of clk.
REQ-025 Reset asserted mid-CLEAR aborts the clear; all registers are still 0 after reset.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN controls write-to-read forwarding.
- When defined: if wr_en=1, state=IDLE, clr_req=0, wr_addr=rd_addrN and the write is not a discarded address-0 write, then rd_dataN = wr_data in the same cycle.
- When undefined: rd_dataN shows the stored value; the new value is visible from the next cycle.
REQ-027 Forwarding never overrides the forced-zero behaviour of REQ-015 and REQ-021.

Structure
REQ-028 A shared package holds the FSM state enum (IDLE, CLEAR) and the default width/depth constants (DATA_W=32, ADDR_W=5).
REQ-029 One sub-module, reg_file_clr_seq, contains the clear FSM and counter; it outputs busy, clr_en and clr_addr.
- The storage array stays in reg_file_mp.

Verification
REQ-030 Basic write/read: write 0xDEADBEEF to r5 with wr_en=1; next cycle set rd_addr1=5 -> rd_data1=0xDEADBEEF.
REQ-031 Zero register: write 0x12345678 to r0 with ZERO_REG=1; set rd_addr2=0 -> rd_data2=0x00000000.
REQ-032 Bypass: in one cycle write 0xA5A5A5A5 to r7 with rd_addr1=7.
- With REGFILE_BYPASS_EN defined -> rd_data1=0xA5A5A5A5 in that cycle.
- Without it -> the old value in that cycle, 0xA5A5A5A5 on the next cycle.
REQ-033 Bulk clear: fill r1..r31 with nonzero values, pulse clr_req.
- busy is high for exactly 32 cycles.
- rd_data is 0 throughout.
- A write to r3 during busy is dropped.
- After busy falls, every register reads 0.
REQ-034 Simultaneous clr_req and wr_en in IDLE to r9=0x1 -> clear starts and r9 reads 0 after completion.
REQ-035 Reset mid-clear: assert rst at clear cycle 10 -> busy=0 immediately, and every register reads 0 after rst is released.
